// File: rtl/ecc_result_buffer.sv
// ecc_result_buffer: show-ahead FIFO that holds ECC results, with a sticky
// overflow flag and saturating per-class result counters.
module ecc_result_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     operation_done,
  input  logic [1:0]               num_of_errors,
  input  logic                     clr_stats,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [1:0]               rd_errors,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     cnt_clean,
  output logic [CNT_WIDTH-1:0]     cnt_corr,
  output logic [CNT_WIDTH-1:0]     cnt_uncorr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0]     LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]     LVL_FULL = LVL_W'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Each entry keeps the error class above the data word.
  logic [DATA_WIDTH+1:0] mem [DEPTH];

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [CNT_WIDTH-1:0] clean_nxt;
  logic [CNT_WIDTH-1:0] corr_nxt;
  logic [CNT_WIDTH-1:0] uncorr_nxt;
  logic                 overflow_nxt;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  assign rd_valid  = (level != '0);
  assign full      = (level == LVL_FULL);
  assign {rd_errors, rd_data} = mem[rd_ptr];

  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign pop  = rd_valid && rd_ready;
  assign push = operation_done && (!full || pop);
  assign drop = operation_done && full && !pop;

  // Next statistics: a clear zeroes first, so a coincident result still counts once.
  always_comb begin
    clean_nxt    = clr_stats ? '0 : cnt_clean;
    corr_nxt     = clr_stats ? '0 : cnt_corr;
    uncorr_nxt   = clr_stats ? '0 : cnt_uncorr;
    overflow_nxt = (clr_stats ? 1'b0 : overflow) | drop;
    if (operation_done) begin
      case (num_of_errors)
        2'd0:    clean_nxt  = sat_inc(clean_nxt);
        2'd1:    corr_nxt   = sat_inc(corr_nxt);
        default: uncorr_nxt = sat_inc(uncorr_nxt);
      endcase
    end
  end

  // Storage array carries no reset; stale words are hidden behind rd_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {num_of_errors, data_out};
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Statistics counters and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_clean  <= '0;
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
      overflow   <= 1'b0;
    end else begin
      cnt_clean  <= clean_nxt;
      cnt_corr   <= corr_nxt;
      cnt_uncorr <= uncorr_nxt;
      overflow   <= overflow_nxt;
    end
  end

endmodule
